rv32_m_lsu: RTL and testbench

- Memory-stage load/store unit. It consumes the execute-to-memory pipeline outputs: control, ALU result as address, store data, instruction and exceptions.
- It performs data-memory accesses over a req/ack bus, aligns store data, and extracts and extends load data.
- It drives `stall_m_o` back to the execute stage's M-stall input while an access is outstanding.
- It owns the memory-to-writeback pipeline register.

---
 rtl/rv32_lsu_pkg.sv | 22 ++
 rtl/rv32_m_load_align.sv | 26 ++
 rtl/rv32_m_lsu.sv | 162 ++++++++++++++++
 tb/tb_rv32_m_lsu.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_lsu_pkg.sv
// rtl/rv32_lsu_pkg.sv - shared types and constants for the memory-stage load/store unit
package rv32_lsu_pkg;

    typedef enum logic {IDLE, WAIT} lsu_state_t;

    localparam int EXCEPTION_WIDTH = 8;

    localparam logic [2:0] RESULT_SRC_LOAD = 3'b001;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Bit positions follow the RISC-V mcause numbering.
    localparam int LOAD_MISALIGNED    = 4;
    localparam int LOAD_ACCESS_FAULT  = 5;
    localparam int STORE_MISALIGNED   = 6;
    localparam int STORE_ACCESS_FAULT = 7;

endpackage

// File: rtl/rv32_m_load_align.sv
// rtl/rv32_m_load_align.sv - lane select and sign/zero extension of a loaded word
module rv32_m_load_align
    import rv32_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr, 3'b000};

    always_comb begin
        data = shifted;
        case (funct3)
            F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  data = {24'd0, shifted[7:0]};
            F3_LHU:  data = {16'd0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/rv32_m_lsu.sv
// rtl/rv32_m_lsu.sv - memory-stage load/store unit with req/ack data bus and M/W pipeline register
module rv32_m_lsu
    import rv32_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       reg_write_i,
    input  logic                       fp_reg_write_i,
    input  logic                       memory_write_i,
    input  logic [2:0]                 result_source_i,
    input  logic [EXCEPTION_WIDTH-1:0] exceptions_i,
    input  logic [31:0]                instr_i,
    input  logic [31:0]                pc_next_i,
    input  logic [31:0]                alu_result_i,
    input  logic [31:0]                write_data_i,
    input  logic [31:0]                fpu_result_i,
    output logic                       dmem_req_o,
    output logic                       dmem_we_o,
    output logic [31:0]                dmem_addr_o,
    output logic [3:0]                 dmem_be_o,
    output logic [31:0]                dmem_wdata_o,
    input  logic                       dmem_ack_i,
    input  logic                       dmem_err_i,
    input  logic [31:0]                dmem_rdata_i,
    output logic                       stall_m_o,
    output logic                       reg_write_o,
    output logic                       fp_reg_write_o,
    output logic [2:0]                 result_source_o,
    output logic [EXCEPTION_WIDTH-1:0] exceptions_o,
    output logic [31:0]                instr_o,
    output logic [31:0]                pc_next_o,
    output logic [31:0]                alu_result_o,
    output logic [31:0]                read_data_o,
    output logic [31:0]                fpu_result_o
);

    lsu_state_t                 state, state_n;
    logic [CNT_W-1:0]           cnt, cnt_n;
    logic                       timeout;
    logic                       is_load, is_store, is_half, is_word;
    logic                       misaligned, access, fault;
    logic [1:0]                 addr_lo;
    logic [3:0]                 be;
    logic [31:0]                load_data;
    logic [EXCEPTION_WIDTH-1:0] exc_add;

    assign addr_lo  = alu_result_i[1:0];
    assign is_load  = (result_source_i == RESULT_SRC_LOAD);
    assign is_store = memory_write_i;
    assign is_half  = (instr_i[13:12] == 2'b01);
    assign is_word  = instr_i[13];

    assign misaligned = (is_load | is_store) & ((is_half & addr_lo[0]) | (is_word & |addr_lo));
    assign access     = (is_load | is_store) & ~|exceptions_i & ~misaligned;

    always_comb begin
        be           = 4'b1111;
        dmem_wdata_o = write_data_i;
        case (instr_i[13:12])
            2'b00: begin
                be           = 4'b0001 << addr_lo;
                dmem_wdata_o = {4{write_data_i[7:0]}};
            end
            2'b01: begin
                be           = 4'b0011 << {addr_lo[1], 1'b0};
                dmem_wdata_o = {2{write_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Request is gated by reset so an access in flight is dropped the moment reset asserts.
    assign dmem_req_o  = access & rst_n_i;
    assign dmem_we_o   = dmem_req_o & is_store;
    assign dmem_be_o   = dmem_req_o ? be : 4'b0000;
    assign dmem_addr_o = {alu_result_i[31:2], 2'b00};

    assign stall_m_o = dmem_req_o & ~dmem_ack_i & ~timeout;
    assign fault     = (dmem_req_o & dmem_ack_i & dmem_err_i) | timeout;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        timeout = 1'b0;
        case (state)
            IDLE: begin
                if (access && !dmem_ack_i) begin
                    state_n = WAIT;
                    cnt_n   = '0;
                end
            end
            WAIT: begin
                if (!access || dmem_ack_i) begin
                    state_n = IDLE;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    rv32_m_load_align u_load_align (
        .funct3 (instr_i[14:12]),
        .addr   (addr_lo),
        .rdata  (dmem_rdata_i),
        .data   (load_data)
    );

    always_comb begin
        exc_add                     = '0;
        exc_add[LOAD_MISALIGNED]    = misaligned & is_load;
        exc_add[STORE_MISALIGNED]   = misaligned & is_store;
        exc_add[LOAD_ACCESS_FAULT]  = fault & is_load;
        exc_add[STORE_ACCESS_FAULT] = fault & is_store;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            reg_write_o     <= 1'b0;
            fp_reg_write_o  <= 1'b0;
            result_source_o <= '0;
            exceptions_o    <= '0;
            instr_o         <= '0;
            pc_next_o       <= '0;
            alu_result_o    <= '0;
            read_data_o     <= '0;
            fpu_result_o    <= '0;
        end else if (stall_m_o) begin
            reg_write_o    <= 1'b0;
            fp_reg_write_o <= 1'b0;
            exceptions_o   <= '0;
        end else begin
            reg_write_o     <= reg_write_i & ~misaligned & ~fault;
            fp_reg_write_o  <= fp_reg_write_i & ~misaligned & ~fault;
            result_source_o <= result_source_i;
            exceptions_o    <= exceptions_i | exc_add;
            instr_o         <= instr_i;
            pc_next_o       <= pc_next_i;
            alu_result_o    <= alu_result_i;
            read_data_o     <= is_load ? load_data : 32'd0;
            fpu_result_o    <= fpu_result_i;
        end
    end

endmodule

// File: tb/tb_rv32_m_lsu.sv
// tb/tb_rv32_m_lsu.sv - scoreboard testbench for rv32_m_lsu
module tb_rv32_m_lsu;
    import rv32_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        reg_write_i, fp_reg_write_i, memory_write_i;
    logic [2:0]  result_source_i;
    logic [7:0]  exceptions_i;
    logic [31:0] instr_i, pc_next_i, alu_result_i, write_data_i, fpu_result_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i, dmem_err_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_m_o, reg_write_o, fp_reg_write_o;
    logic [2:0]  result_source_o;
    logic [7:0]  exceptions_o;
    logic [31:0] instr_o, pc_next_o, alu_result_o, read_data_o, fpu_result_o;

    rv32_m_lsu #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .reg_write_i(reg_write_i), .fp_reg_write_i(fp_reg_write_i), .memory_write_i(memory_write_i),
        .result_source_i(result_source_i), .exceptions_i(exceptions_i),
        .instr_i(instr_i), .pc_next_i(pc_next_i), .alu_result_i(alu_result_i),
        .write_data_i(write_data_i), .fpu_result_i(fpu_result_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_err_i(dmem_err_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_m_o(stall_m_o), .reg_write_o(reg_write_o), .fp_reg_write_o(fp_reg_write_o),
        .result_source_o(result_source_o), .exceptions_o(exceptions_o),
        .instr_o(instr_o), .pc_next_o(pc_next_o), .alu_result_o(alu_result_o),
        .read_data_o(read_data_o), .fpu_result_o(fpu_result_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        fprw;
        logic [2:0]  rs;
        logic [7:0]  exc;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [31:0] pc;
        int          stalls;
    } w_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    w_exp_t   wq[$];
    bus_exp_t bq[$];
    int       tests = 0;
    int       fails = 0;
    logic     tb_valid = 1'b0;
    logic [31:0] pc_seq = 32'h0000_1000;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Monitor: W-stage records, bubble checks and bus request starts.
    logic w_pend = 1'b0, bub_pend = 1'b0, req_cont = 1'b0;
    int   stall_cnt = 0, stall_snap = 0;

    always @(negedge clk) begin
        if (!rst_n_i) begin
            w_pend = 1'b0; bub_pend = 1'b0; req_cont = 1'b0;
            stall_cnt = 0; stall_snap = 0;
        end else begin
            if (w_pend) begin
                if (wq.size() == 0) begin
                    chk("w_unexpected", 32'd1, 32'd0);
                end else begin
                    w_exp_t e;
                    e = wq.pop_front();
                    chk("w_reg_write",    {31'd0, reg_write_o},    {31'd0, e.rw});
                    chk("w_fp_reg_write", {31'd0, fp_reg_write_o}, {31'd0, e.fprw});
                    chk("w_result_src",   {29'd0, result_source_o}, {29'd0, e.rs});
                    chk("w_exceptions",   {24'd0, exceptions_o},   {24'd0, e.exc});
                    chk("w_read_data",    read_data_o,  e.rd);
                    chk("w_alu_result",   alu_result_o, e.alu);
                    chk("w_pc_next",      pc_next_o,    e.pc);
                    chk("stall_cycles",   stall_snap,   e.stalls);
                end
            end else if (bub_pend) begin
                chk("bubble_reg_write", {31'd0, reg_write_o}, 32'd0);
                chk("bubble_exc",       {24'd0, exceptions_o}, 32'd0);
            end
            if (dmem_req_o && !req_cont) begin
                if (bq.size() == 0) begin
                    chk("bus_unexpected_req", 32'd1, 32'd0);
                end else begin
                    bus_exp_t b;
                    b = bq.pop_front();
                    chk("bus_we",    {31'd0, dmem_we_o}, {31'd0, b.we});
                    chk("bus_addr",  dmem_addr_o,  b.addr);
                    chk("bus_be",    {28'd0, dmem_be_o}, {28'd0, b.be});
                    chk("bus_wdata", dmem_wdata_o, b.wdata);
                end
            end
            req_cont = dmem_req_o && stall_m_o;
            w_pend   = tb_valid && !stall_m_o;
            bub_pend = tb_valid && stall_m_o;
            if (tb_valid && stall_m_o) stall_cnt++;
            if (w_pend) begin
                stall_snap = stall_cnt;
                stall_cnt  = 0;
            end
        end
    end

    task automatic idle_inputs();
        reg_write_i = 0; fp_reg_write_i = 0; memory_write_i = 0;
        result_source_i = 3'b000; exceptions_i = 8'h00;
        instr_i = 32'h0000_0013; alu_result_i = 0; write_data_i = 0;
        fpu_result_i = 0; pc_next_i = 0; dmem_rdata_i = 0;
        dmem_ack_i = 0; dmem_err_i = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the instruction enters W.
    task automatic issue(input logic [2:0] f3, input logic [2:0] rs, input logic mw,
                         input logic rw, input logic fprw, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata, input int d,
                         input logic err, input logic erw, input logic efprw,
                         input logic [7:0] eexc, input logic [31:0] erd, input int estalls,
                         input logic ebus, input logic [31:0] eaddr, input logic [3:0] ebe,
                         input logic [31:0] ewd);
        int   cyc;
        logic done;
        bus_exp_t b;
        w_exp_t   w;
        pc_seq = pc_seq + 32'd4;
        if (ebus) begin
            b.we = mw; b.addr = eaddr; b.be = ebe; b.wdata = ewd;
            bq.push_back(b);
        end
        w.rw = erw; w.fprw = efprw; w.rs = rs; w.exc = eexc; w.rd = erd;
        w.alu = addr; w.pc = pc_seq; w.stalls = estalls;
        wq.push_back(w);
        instr_i = {17'd0, f3, 12'h003};
        result_source_i = rs; memory_write_i = mw; reg_write_i = rw; fp_reg_write_i = fprw;
        alu_result_i = addr; write_data_i = wd; dmem_rdata_i = rdata; pc_next_i = pc_seq;
        exceptions_i = 8'h00; fpu_result_i = 32'hCAFE_0000;
        tb_valid = 1'b1;
        cyc = 0;
        dmem_ack_i = (d == 0);
        dmem_err_i = err && (d == 0);
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            done = !stall_m_o;
            @(posedge clk);
            #1;
            if (done) break;
            cyc++;
            if (cyc > 100) begin
                tests++; fails++;
                $display("FAIL issue_bound actual=%0d required<=100", cyc);
                break;
            end
            dmem_ack_i = (cyc == d);
            dmem_err_i = err && (cyc == d);
        end
        tb_valid = 1'b0;
        idle_inputs();
    endtask

    initial begin
        bus_exp_t b;
        rst_n_i = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   {31'd0, dmem_req_o},  32'd0);
        chk("rst_stall", {31'd0, stall_m_o},   32'd0);
        chk("rst_rw",    {31'd0, reg_write_o}, 32'd0);
        chk("rst_exc",   {24'd0, exceptions_o}, 32'd0);
        chk("rst_rd",    read_data_o, 32'd0);
        rst_n_i = 1'b1;
        @(posedge clk);
        #1;

        // f3   rs    mw rw fp addr           wd             rdata          d  err | erw efp exc    erd            st bus eaddr          be       ewd
        issue(3'b010, 3'b000, 1, 0, 0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         0, 0,   0, 0, 8'h00, 32'h0,         0, 1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
        issue(3'b000, 3'b001, 0, 1, 0, 32'h0000_0203, 32'h0,         32'h80FF_0000, 3, 0,   1, 0, 8'h00, 32'hFFFF_FF80, 3, 1, 32'h0000_0200, 4'b1000, 32'h0);
        issue(3'b101, 3'b001, 0, 1, 0, 32'h0000_0102, 32'h0,         32'hBEEF_1234, 1, 0,   1, 0, 8'h00, 32'h0000_BEEF, 1, 1, 32'h0000_0100, 4'b1100, 32'h0);
        issue(3'b000, 3'b000, 1, 0, 0, 32'h0000_0101, 32'h0000_00AB, 32'h0,         0, 0,   0, 0, 8'h00, 32'h0,         0, 1, 32'h0000_0100, 4'b0010, 32'hABAB_ABAB);
        issue(3'b010, 3'b001, 0, 1, 0, 32'h0000_0102, 32'h0,         32'h0,         0, 0,   0, 0, 8'h10, 32'h0,         0, 0, 32'h0,         4'b0000, 32'h0);
        issue(3'b010, 3'b001, 0, 0, 1, 32'h0000_0204, 32'h0,         32'h3F80_0000, 0, 0,   0, 1, 8'h00, 32'h3F80_0000, 0, 1, 32'h0000_0204, 4'b1111, 32'h0);
        issue(3'b010, 3'b001, 0, 1, 0, 32'h0000_0200, 32'h0,         32'h0,        -1, 0,   0, 0, 8'h20, 32'h0,        16, 1, 32'h0000_0200, 4'b1111, 32'h0);
        issue(3'b010, 3'b000, 1, 0, 0, 32'h0000_0300, 32'h1234_5678, 32'h0,         2, 1,   0, 0, 8'h80, 32'h0,         2, 1, 32'h0000_0300, 4'b1111, 32'h1234_5678);

        // Reset in the middle of a waiting load.
        b.we = 1'b0; b.addr = 32'h0000_0400; b.be = 4'b1111; b.wdata = 32'h0;
        bq.push_back(b);
        instr_i = {17'd0, 3'b010, 12'h003};
        result_source_i = 3'b001; reg_write_i = 1'b1; alu_result_i = 32'h0000_0400;
        pc_next_i = 32'h0000_2000;
        tb_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("wait_stall", {31'd0, stall_m_o}, 32'd1);
        rst_n_i = 1'b0;
        #1;
        chk("midrst_req",   {31'd0, dmem_req_o},  32'd0);
        chk("midrst_stall", {31'd0, stall_m_o},   32'd0);
        chk("midrst_be",    {28'd0, dmem_be_o},   32'd0);
        chk("midrst_alu",   alu_result_o, 32'd0);
        chk("midrst_pc",    pc_next_o,    32'd0);
        tb_valid = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n_i = 1'b1;
        @(posedge clk);
        #1;
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'hFFFF_FFFF;
        #1;
        chk("late_ack_req",   {31'd0, dmem_req_o}, 32'd0);
        chk("late_ack_stall", {31'd0, stall_m_o},  32'd0);
        @(posedge clk);
        #1;
        dmem_ack_i = 1'b0;
        chk("late_ack_rw", {31'd0, reg_write_o},  32'd0);
        chk("late_ack_rd", read_data_o, 32'd0);

        issue(3'b001, 3'b001, 0, 1, 0, 32'h0000_0502, 32'h0, 32'h8001_0000, 2, 0, 1, 0, 8'h00, 32'hFFFF_8001, 2, 1, 32'h0000_0500, 4'b1100, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("wq_drained", wq.size(), 32'd0);
        chk("bq_drained", bq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule
